rgb_led_scheduler: RTL and testbench
====================================

Name: rgb_led_scheduler

Overview:
Time-shares each player's RGB LED between a steady "coin colour" display and a white flash sequence triggered on coin collection. A shared PWM generator dims the display. Sits between the coin counters and the board RGB LED pins, and replaces direct bit-to-pin wiring. Two independent player channels share one PWM timebase.

Parameters:
PWM_BITS, 8, width of PWM counter and brightness input.
PWM_DIV, 16, clocks per PWM counter increment (≥1); PWM period = PWM_DIV * 2^PWM_BITS clocks.
FLASH_TICKS, 10_000_000, clocks per flash half-phase (ON or OFF), ≥1.
FLASH_COUNT, 3, ON/OFF pairs per flash sequence, ≥1.

Ports:
CLK100MHZ  in  1  system clock; single clock domain
CPU_RESETN  in  1  synchronous, active-low reset
enable  in  1  0 = all LEDs dark, FSMs held in IDLE, events ignored
brightness  in  PWM_BITS  duty value, 0 = off
coin1  in  3  player 1 colour code {R,G,B}
coin2  in  3  player 2 colour code {R,G,B}
coin_evt1  in  1  one-cycle pulse, player 1 collected a coin
coin_evt2  in  1  one-cycle pulse, player 2 collected a coin
LED1_R, LED1_G, LED1_B  out  1 each  player 1 RGB pins
LED2_R, LED2_G, LED2_B  out  1 each  player 2 RGB pins
busy1, busy2  out  1 each  high while that channel is in a flash sequence

Behaviour:
- Reset (CPU_RESETN=0 at edge): all LED outputs 0, busy 0, PWM counter and prescaler 0, shadow brightness 0, both FSMs in IDLE. Reset overrides every other input.
- Prescaler counts 0..PWM_DIV-1. pwm_cnt increments when the prescaler wraps; pwm_cnt wraps from 2^PWM_BITS-1 to 0.
- Shadow brightness loads from brightness only when pwm_cnt wraps to 0, so no mid-period glitch. pwm_on = (pwm_cnt < shadow). Brightness 0 gives a constant 0; max gives a duty of (2^PWM_BITS-1)/2^PWM_BITS.
- Per-channel FSM states: IDLE, FLASH_ON, FLASH_OFF.
- IDLE: coin_evt=1 and enable=1 → FLASH_ON, phase counter 0, pair counter 0.
- FLASH_ON: after FLASH_TICKS clocks → FLASH_OFF.
- FLASH_OFF: after FLASH_TICKS clocks → FLASH_ON if pairs done < FLASH_COUNT-1, else IDLE.
- coin_evt in FLASH_ON or FLASH_OFF retriggers: → FLASH_ON with both counters cleared.
- busy = (state != IDLE).
- Output mux, registered:
  - IDLE: LED = coin & {3{pwm_on}}.
  - FLASH_ON: LED = {3{pwm_on}} (white).
  - FLASH_OFF: LED = 000.
- Latency: an event sampled at edge k puts the FSM in FLASH_ON after edge k; the LED pins reflect it after edge k+1. A coin input change appears on the pins one edge after sampling.
- enable=0: FSMs forced to IDLE at the next edge (aborts any flash) and outputs register to 0. The PWM counter keeps running.
- Events on both channels in the same cycle are handled independently; there is no cross-channel priority.
- Entering reset mid-flash → IDLE. No residual state survives reset.

Decomposition:
- Shared include led_defs.vh holds:
  - FSM state encodings: IDLE=2'd0, FLASH_ON=2'd1, FLASH_OFF=2'd2.
  - Colour code constants: RED=3'b100, GREEN=3'b010, BLUE=3'b001, WHITE=3'b111, OFF=3'b000.
- Sub-module led_flash_fsm (FSM + phase/pair counters + busy) is instantiated once per player. The PWM timebase and output registers live in the top module.

Test Plan:
All tests use PWM_BITS=4, PWM_DIV=1, FLASH_TICKS=4, FLASH_COUNT=2.
1. Reset: hold CPU_RESETN=0 for 3 cycles with coin1=111, brightness=15, evt1=1 → all LEDs 0 and busy 0 throughout. Release → IDLE; LED1 follows coin1 & pwm_on.
2. PWM: enable=1, coin1=100, brightness=4 → LED1_R high 4 of every 16 cycles; G and B stay 0. Change brightness to 12 mid-period → new duty only from the next wrap. brightness=0 → R never high.
3. Flash: brightness=15, pulse evt1 at edge k → busy1=1 after k. LED1 = white-gated for 4 cycles from k+1, then 000 for 4, white for 4, 000 for 4. busy1=0 after edge k+16; LED1 returns to coin1.
4. Retrigger: pulse evt1 at k, again at k+6 (in FLASH_OFF) → FLASH_ON at k+6 and full 16-cycle sequence restarts; busy1 drops after k+22.
5. Simultaneous and abort: evt1 and evt2 in the same cycle → identical independent sequences. Drop enable at k+5 → both IDLE, all LEDs 0 from k+6, busy 0. Reset mid-flash → IDLE.

Source files
------------

// File: rtl/rgb_led_scheduler_pkg.sv
// Shared types and helpers for the RGB LED scheduler: flash FSM states, colour codes, output mux.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package rgb_led_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLASH_ON  = 2'd1,
    FLASH_OFF = 2'd2
  } flash_state_t;

  // Colour codes are {R,G,B}
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_BLUE  = 3'b001;
  localparam logic [2:0] COL_WHITE = 3'b111;
  localparam logic [2:0] COL_OFF   = 3'b000;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Next LED value for one channel, given its flash state and the shared PWM gate.
  function automatic logic [2:0] led_mux(input flash_state_t st,
                                         input logic [2:0]   coin,
                                         input logic         pwm_on);
    case (st)
      IDLE:     return coin & {3{pwm_on}};
      FLASH_ON: return COL_WHITE & {3{pwm_on}};
      default:  return COL_OFF;
    endcase
  endfunction

endpackage

// File: rtl/led_flash_fsm.sv
// Per-player flash sequencer: FLASH_COUNT ON/OFF pairs of FLASH_TICKS clocks each, retriggerable.
// Latency: event sampled at edge k -> FLASH_ON (busy=1) after edge k.
// Backpressure: none; events arriving mid-sequence restart it, events are ignored while enable=0.
// Ports: core_clk, rst_n (sync active-low), enable, coin_evt (1-cycle pulse) -> state, busy.
module led_flash_fsm
  import rgb_led_scheduler_pkg::*;
#(
  parameter int FLASH_TICKS = 10_000_000,
  parameter int FLASH_COUNT = 3
) (
  input  logic         core_clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         coin_evt,
  output flash_state_t state,
  output logic         busy
);

  localparam int PH_W   = cnt_w(FLASH_TICKS);
  localparam int PAIR_W = cnt_w(FLASH_COUNT);

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(FLASH_TICKS - 1);
  localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'(FLASH_COUNT - 1);

  flash_state_t      state_nxt;
  logic [PH_W-1:0]   phase, phase_nxt;   // clocks spent in current half-phase
  logic [PAIR_W-1:0] pair, pair_nxt;     // ON/OFF pairs completed

  always_ff @(posedge core_clk) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= '0;
      pair  <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      pair  <= pair_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    pair_nxt  = pair;
    if (!enable) begin
      // Disable aborts any flash in progress and masks events.
      state_nxt = IDLE;
      phase_nxt = '0;
      pair_nxt  = '0;
    end else if (coin_evt) begin
      // Same action from every state: start (or restart) the sequence.
      state_nxt = FLASH_ON;
      phase_nxt = '0;
      pair_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          phase_nxt = '0;
          pair_nxt  = '0;
        end
        FLASH_ON: begin
          if (phase == PH_LAST) begin
            state_nxt = FLASH_OFF;
            phase_nxt = '0;
          end else begin
            phase_nxt = phase + PH_W'(1);
          end
        end
        FLASH_OFF: begin
          if (phase == PH_LAST) begin
            phase_nxt = '0;
            if (pair == PAIR_LAST) begin
              state_nxt = IDLE;
              pair_nxt  = '0;
            end else begin
              state_nxt = FLASH_ON;
              pair_nxt  = pair + PAIR_W'(1);
            end
          end else begin
            phase_nxt = phase + PH_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          phase_nxt = '0;
          pair_nxt  = '0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/rgb_led_scheduler.sv
// Time-shares two players' RGB LEDs between PWM-dimmed coin colour and a white flash sequence.
// Latency: coin/state change -> pins one edge later (LED outputs are registered).
// Backpressure: none; free-running PWM timebase, events restart flashes, enable=0 blanks all LEDs.
// Ports: CLK100MHZ, CPU_RESETN (sync active-low), enable, brightness, coin1/2 {R,G,B},
//        coin_evt1/2 (1-cycle pulses) -> LED1_R/G/B, LED2_R/G/B, busy1/2.
module rgb_led_scheduler
  import rgb_led_scheduler_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int PWM_DIV     = 16,
  parameter int FLASH_TICKS = 10_000_000,
  parameter int FLASH_COUNT = 3
) (
  input  logic                CLK100MHZ,
  input  logic                CPU_RESETN,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic [2:0]          coin1,
  input  logic [2:0]          coin2,
  input  logic                coin_evt1,
  input  logic                coin_evt2,
  output logic                LED1_R,
  output logic                LED1_G,
  output logic                LED1_B,
  output logic                LED2_R,
  output logic                LED2_G,
  output logic                LED2_B,
  output logic                busy1,
  output logic                busy2
);

  localparam int                PRE_W    = cnt_w(PWM_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PWM_DIV - 1);

  logic [PRE_W-1:0]    presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] shadow;
  logic                presc_wrap;
  logic                pwm_on;
  flash_state_t        st1, st2;
  logic [2:0]          led1_q, led2_q;

  assign presc_wrap = (presc == PRE_LAST);

  // Shared PWM timebase. Runs regardless of enable so both channels stay phase-aligned.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      presc   <= '0;
      pwm_cnt <= '0;
      shadow  <= '0;
    end else begin
      presc <= presc_wrap ? '0 : presc + PRE_W'(1);
      if (presc_wrap) begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        // Brightness is captured only as the counter rolls over to 0, so a
        // period never mixes two duty values.
        if (pwm_cnt == '1) begin
          shadow <= brightness;
        end
      end
    end
  end

  // Strict compare: full-scale brightness gives 2^N-1 on-counts out of 2^N.
  assign pwm_on = (pwm_cnt < shadow);

  led_flash_fsm #(
    .FLASH_TICKS (FLASH_TICKS),
    .FLASH_COUNT (FLASH_COUNT)
  ) u_fsm1 (
    .core_clk (CLK100MHZ),
    .rst_n    (CPU_RESETN),
    .enable   (enable),
    .coin_evt (coin_evt1),
    .state    (st1),
    .busy     (busy1)
  );

  led_flash_fsm #(
    .FLASH_TICKS (FLASH_TICKS),
    .FLASH_COUNT (FLASH_COUNT)
  ) u_fsm2 (
    .core_clk (CLK100MHZ),
    .rst_n    (CPU_RESETN),
    .enable   (enable),
    .coin_evt (coin_evt2),
    .state    (st2),
    .busy     (busy2)
  );

  // Registered pin drive: uses the FSM state as it stands before the edge,
  // so a flash shows on the pins one edge after the FSM enters it.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      led1_q <= COL_OFF;
      led2_q <= COL_OFF;
    end else if (!enable) begin
      led1_q <= COL_OFF;
      led2_q <= COL_OFF;
    end else begin
      led1_q <= led_mux(st1, coin1, pwm_on);
      led2_q <= led_mux(st2, coin2, pwm_on);
    end
  end

  assign {LED1_R, LED1_G, LED1_B} = led1_q;
  assign {LED2_R, LED2_G, LED2_B} = led2_q;

endmodule

// File: tb/tb_rgb_led_scheduler.sv
// Bench for rgb_led_scheduler with small parameters (PWM 4 bits, DIV 1, 4-tick phases, 2 pairs).
// Reference model tracks elapsed time since reset and remaining flash time per channel.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_rgb_led_scheduler;
  import rgb_led_scheduler_pkg::*;

  localparam int PB  = 4;
  localparam int DIV = 1;
  localparam int FT  = 4;
  localparam int FC  = 2;
  localparam int SEQ = 2 * FC * FT;      // clocks in a full flash sequence
  localparam int PER = DIV * (1 << PB);  // clocks per PWM period

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [PB-1:0] brightness;
  logic [2:0]    coin1, coin2;
  logic          evt1, evt2;
  logic          led1_r, led1_g, led1_b, led2_r, led2_g, led2_b;
  logic          busy1, busy2;

  always #5 clk = ~clk;

  rgb_led_scheduler #(
    .PWM_BITS    (PB),
    .PWM_DIV     (DIV),
    .FLASH_TICKS (FT),
    .FLASH_COUNT (FC)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .enable     (enable),
    .brightness (brightness),
    .coin1      (coin1),
    .coin2      (coin2),
    .coin_evt1  (evt1),
    .coin_evt2  (evt2),
    .LED1_R     (led1_r),
    .LED1_G     (led1_g),
    .LED1_B     (led1_b),
    .LED2_R     (led2_r),
    .LED2_G     (led2_g),
    .LED2_B     (led2_b),
    .busy1      (busy1),
    .busy2      (busy2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int          m_n;          // clock edges since reset released
  logic [PB-1:0] m_shadow;
  int          m_left[2];    // clocks of flash sequence still to run (0 = idle)
  logic [2:0]  m_led[2];

  task automatic model_step();
    int          cnt;
    logic        on;
    logic [2:0]  c;
    logic        e;
    cnt = (m_n / DIV) % (1 << PB);
    on  = (cnt < int'(m_shadow));
    if (!rst_n) begin
      m_n      = 0;
      m_shadow = '0;
      for (int ch = 0; ch < 2; ch++) begin
        m_left[ch] = 0;
        m_led[ch]  = 3'b000;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        c = (ch == 0) ? coin1 : coin2;
        e = (ch == 0) ? evt1 : evt2;
        if (!enable)
          m_led[ch] = 3'b000;
        else if (m_left[ch] == 0)
          m_led[ch] = c & {3{on}};
        else if ((((SEQ - m_left[ch]) / FT) % 2) == 0)
          m_led[ch] = {3{on}};
        else
          m_led[ch] = 3'b000;
        if (!enable)          m_left[ch] = 0;
        else if (e)           m_left[ch] = SEQ;
        else if (m_left[ch] > 0) m_left[ch] = m_left[ch] - 1;
      end
      m_n++;
      if (m_n % PER == 0) m_shadow = brightness;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("led1", {29'd0, led1_r, led1_g, led1_b}, {29'd0, m_led[0]});
    chk("led2", {29'd0, led2_r, led2_g, led2_b}, {29'd0, m_led[1]});
    chk("busy1", {31'd0, busy1}, {31'd0, (m_left[0] != 0)});
    chk("busy2", {31'd0, busy2}, {31'd0, (m_left[1] != 0)});
  endtask

  int hi;

  initial begin
    rst_n = 1'b0; enable = 1'b1; brightness = 4'd15;
    coin1 = COL_WHITE; coin2 = COL_OFF; evt1 = 1'b1; evt2 = 1'b0;

    // Reset dominates a pending event and full brightness
    repeat (3) step();
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    rst_n = 1'b1; evt1 = 1'b0;
    repeat (20) step();

    // Duty cycle at brightness 4, then 12 (changed mid-period), then 0
    coin1 = COL_RED; brightness = 4'd4;
    repeat (32) step();
    hi = 0;
    repeat (PER) begin step(); hi += int'(led1_r); end
    chk("duty_b4", hi, 4);
    repeat (5) step();
    brightness = 4'd12;
    repeat (40) step();
    hi = 0;
    repeat (PER) begin step(); hi += int'(led1_r); end
    chk("duty_b12", hi, 12);
    brightness = 4'd0;
    repeat (20) step();
    hi = 0;
    repeat (2 * PER) begin step(); hi += int'(led1_r); end
    chk("duty_b0", hi, 0);

    // Single flash: busy for exactly one sequence
    brightness = 4'd15; coin1 = COL_GREEN;
    repeat (20) step();
    evt1 = 1'b1; step(); evt1 = 1'b0;
    chk("busy_on_evt", {31'd0, busy1}, 32'd1);
    hi = 1;
    repeat (24) begin step(); hi += int'(busy1); end
    chk("busy_len", hi, SEQ);

    // Retrigger during FLASH_OFF restarts the whole sequence
    hi = 0;
    evt1 = 1'b1; step(); evt1 = 1'b0; hi += int'(busy1);
    repeat (5) begin step(); hi += int'(busy1); end
    evt1 = 1'b1; step(); evt1 = 1'b0; hi += int'(busy1);
    repeat (24) begin step(); hi += int'(busy1); end
    chk("retrig_len", hi, 6 + SEQ);

    // Simultaneous events, then abort through enable
    coin2 = COL_BLUE;
    evt1 = 1'b1; evt2 = 1'b1; step(); evt1 = 1'b0; evt2 = 1'b0;
    repeat (4) step();
    enable = 1'b0; step();
    chk("abort_busy1", {31'd0, busy1}, 32'd0);
    chk("abort_busy2", {31'd0, busy2}, 32'd0);
    repeat (3) step();
    enable = 1'b1;
    repeat (5) step();

    // Reset in the middle of a flash
    evt1 = 1'b1; step(); evt1 = 1'b0;
    repeat (3) step();
    rst_n = 1'b0; step();
    chk("rst_mid_busy1", {31'd0, busy1}, 32'd0);
    rst_n = 1'b1;
    repeat (5) step();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      evt1 = ($urandom_range(15) == 0);
      evt2 = ($urandom_range(15) == 0);
      if ($urandom_range(7) == 0)  coin1 = 3'($urandom_range(7));
      if ($urandom_range(7) == 0)  coin2 = 3'($urandom_range(7));
      if ($urandom_range(39) == 0) brightness = 4'($urandom_range(15));
      enable = ($urandom_range(63) != 0);
      rst_n  = ($urandom_range(499) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
